// File: rtl/stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : stage_pkg
//  Description : Shared definitions for the launch stage sequencer: FSM state
//                encoding, the default per-phase engine tables (phases 1..4;
//                the third-stage split burn is phases 3 and 4) and the
//                payload mass.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package stage_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_BURN  = 3'd2,
      ST_SEP   = 3'd3,
      ST_DONE  = 3'd4,
      ST_FAULT = 3'd5
   } state_t;

   localparam int unsigned C_NUM_PHASES = 4;

   // Index 0 is phase 1.
   localparam int unsigned C_ISP_TAB  [C_NUM_PHASES] = '{263, 421, 421, 421};
   localparam int unsigned C_PROP_TAB [C_NUM_PHASES] = '{2077000, 456100, 39136, 83864};
   localparam int unsigned C_BURN_TAB [C_NUM_PHASES] = '{168, 360, 165, 335};
   localparam int unsigned C_DROP_TAB [C_NUM_PHASES] = '{137000, 40100, 0, 15200};

   // LM + CSM
   localparam int unsigned C_PAYLOAD = 27003;

endpackage : stage_pkg
`default_nettype wire

// File: rtl/stage_rom.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : stage_rom
//  Description : Combinational per-phase parameter lookup. Phase numbers
//                outside 1..4 return all zeros.
//  Ports       : i_stage  - phase number (1..4)
//                o_isp    - specific impulse of the phase
//                o_prop   - propellant mass burned in the phase
//                o_burn   - nominal burn time of the phase
//                o_drop   - dry mass jettisoned at the end of the phase
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_rom
   import stage_pkg::*;
#(
   parameter int unsigned N      = 64,
   parameter int unsigned ISP_1  = C_ISP_TAB[0],
   parameter int unsigned ISP_2  = C_ISP_TAB[1],
   parameter int unsigned ISP_3  = C_ISP_TAB[2],
   parameter int unsigned ISP_4  = C_ISP_TAB[3],
   parameter int unsigned PROP_1 = C_PROP_TAB[0],
   parameter int unsigned PROP_2 = C_PROP_TAB[1],
   parameter int unsigned PROP_3 = C_PROP_TAB[2],
   parameter int unsigned PROP_4 = C_PROP_TAB[3],
   parameter int unsigned BURN_1 = C_BURN_TAB[0],
   parameter int unsigned BURN_2 = C_BURN_TAB[1],
   parameter int unsigned BURN_3 = C_BURN_TAB[2],
   parameter int unsigned BURN_4 = C_BURN_TAB[3],
   parameter int unsigned DROP_1 = C_DROP_TAB[0],
   parameter int unsigned DROP_2 = C_DROP_TAB[1],
   parameter int unsigned DROP_3 = C_DROP_TAB[2],
   parameter int unsigned DROP_4 = C_DROP_TAB[3]
)(
   input  logic [3:0]   i_stage,
   output logic [N-1:0] o_isp,
   output logic [N-1:0] o_prop,
   output logic [N-1:0] o_burn,
   output logic [N-1:0] o_drop
);

   always_comb begin
      o_isp  = '0;
      o_prop = '0;
      o_burn = '0;
      o_drop = '0;
      case (i_stage)
         4'd1: begin
            o_isp  = N'(ISP_1);
            o_prop = N'(PROP_1);
            o_burn = N'(BURN_1);
            o_drop = N'(DROP_1);
         end
         4'd2: begin
            o_isp  = N'(ISP_2);
            o_prop = N'(PROP_2);
            o_burn = N'(BURN_2);
            o_drop = N'(DROP_2);
         end
         4'd3: begin
            o_isp  = N'(ISP_3);
            o_prop = N'(PROP_3);
            o_burn = N'(BURN_3);
            o_drop = N'(DROP_3);
         end
         4'd4: begin
            o_isp  = N'(ISP_4);
            o_prop = N'(PROP_4);
            o_burn = N'(BURN_4);
            o_drop = N'(DROP_4);
         end
         default: ;
      endcase
   end

endmodule : stage_rom
`default_nettype wire

// File: rtl/stage_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : stage_sequencer
//  Description : Launch-vehicle burn sequencer. Walks the phases in order,
//                loads the engine parameters of each phase, enables the
//                engine for the burn, tracks the vehicle mass across
//                separations and reports completion or fault.
//  Ports       : CLK, RESETB (async, active-low)
//                START        - one-cycle liftoff request (IDLE only)
//                ABORT        - level, forces FAULT outside IDLE
//                IGNITION_END - burn complete from the velocity engine
//                ENGINE_RUN   - engine enable (engine resetb)
//                SPECIFICIMPULSE / INITIALWEIGHT / WEIGHT_PROPELLANT /
//                BURNTIME     - current-phase engine parameters
//                STAGESTATE   - active phase, 0 = none
//                SEP_PULSE / SEP_ID - one-cycle end-of-phase event + phase
//                DONE / FAULT - sticky status flags
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_sequencer
   import stage_pkg::*;
#(
   parameter int unsigned N          = 64,
   parameter int unsigned NUM_STAGES = 4,
   parameter int unsigned SEP_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 2_000_000,
   parameter int unsigned ISP_1      = C_ISP_TAB[0],
   parameter int unsigned ISP_2      = C_ISP_TAB[1],
   parameter int unsigned ISP_3      = C_ISP_TAB[2],
   parameter int unsigned ISP_4      = C_ISP_TAB[3],
   parameter int unsigned PROP_1     = C_PROP_TAB[0],
   parameter int unsigned PROP_2     = C_PROP_TAB[1],
   parameter int unsigned PROP_3     = C_PROP_TAB[2],
   parameter int unsigned PROP_4     = C_PROP_TAB[3],
   parameter int unsigned BURN_1     = C_BURN_TAB[0],
   parameter int unsigned BURN_2     = C_BURN_TAB[1],
   parameter int unsigned BURN_3     = C_BURN_TAB[2],
   parameter int unsigned BURN_4     = C_BURN_TAB[3],
   parameter int unsigned DROP_1     = C_DROP_TAB[0],
   parameter int unsigned DROP_2     = C_DROP_TAB[1],
   parameter int unsigned DROP_3     = C_DROP_TAB[2],
   parameter int unsigned DROP_4     = C_DROP_TAB[3],
   parameter int unsigned PAYLOAD    = C_PAYLOAD
)(
   input  logic         CLK,
   input  logic         RESETB,
   input  logic         START,
   input  logic         ABORT,
   input  logic         IGNITION_END,
   output logic         ENGINE_RUN,
   output logic [N-1:0] SPECIFICIMPULSE,
   output logic [N-1:0] INITIALWEIGHT,
   output logic [N-1:0] WEIGHT_PROPELLANT,
   output logic [N-1:0] BURNTIME,
   output logic [3:0]   STAGESTATE,
   output logic         SEP_PULSE,
   output logic [3:0]   SEP_ID,
   output logic         DONE,
   output logic         FAULT
);

   // Liftoff mass: every propellant load, every jettisoned dry mass, payload.
   localparam logic [N-1:0] C_LIFTOFF_MASS =
      N'(PROP_1) + N'(PROP_2) + N'(PROP_3) + N'(PROP_4) +
      N'(DROP_1) + N'(DROP_2) + N'(DROP_3) + N'(DROP_4) + N'(PAYLOAD);

   localparam logic [31:0] C_BURN_LAST = 32'(TIMEOUT - 1);
   localparam logic [31:0] C_SEP_LAST  = 32'(SEP_CYCLES - 1);

   state_t       r_state, w_state_nxt;
   logic [3:0]   r_stage, w_stage_nxt;
   logic [N-1:0] r_mass, w_mass_nxt;
   logic [31:0]  r_cnt, w_cnt_nxt;
   logic         r_run, w_run_nxt;
   logic         r_pulse, w_pulse_nxt;
   logic [3:0]   r_sep_id, w_sep_id_nxt;
   logic [N-1:0] r_isp, w_isp_nxt;
   logic [N-1:0] r_iw, w_iw_nxt;
   logic [N-1:0] r_wp, w_wp_nxt;
   logic [N-1:0] r_bt, w_bt_nxt;
   logic         r_done, w_done_nxt;
   logic         r_fault, w_fault_nxt;

   logic [N-1:0] w_rom_isp, w_rom_prop, w_rom_burn, w_rom_drop;
   logic [N-1:0] w_jettison;
   logic         w_underflow;
   logic         w_abort;

   stage_rom #(
      .N      (N),
      .ISP_1  (ISP_1),  .ISP_2  (ISP_2),  .ISP_3  (ISP_3),  .ISP_4  (ISP_4),
      .PROP_1 (PROP_1), .PROP_2 (PROP_2), .PROP_3 (PROP_3), .PROP_4 (PROP_4),
      .BURN_1 (BURN_1), .BURN_2 (BURN_2), .BURN_3 (BURN_3), .BURN_4 (BURN_4),
      .DROP_1 (DROP_1), .DROP_2 (DROP_2), .DROP_3 (DROP_3), .DROP_4 (DROP_4)
   ) u_rom (
      .i_stage (r_stage),
      .o_isp   (w_rom_isp),
      .o_prop  (w_rom_prop),
      .o_burn  (w_rom_burn),
      .o_drop  (w_rom_drop)
   );

   assign w_jettison  = w_rom_prop + w_rom_drop;
   assign w_underflow = (r_mass < w_jettison);

   // ABORT acts only while a flight is in progress; DONE and FAULT are
   // terminal and hold until reset, IDLE ignores everything but START.
   assign w_abort = ABORT && ((r_state == ST_LOAD) || (r_state == ST_BURN) ||
                              (r_state == ST_SEP));

   always_comb begin
      w_state_nxt  = r_state;
      w_stage_nxt  = r_stage;
      w_mass_nxt   = r_mass;
      w_cnt_nxt    = r_cnt;
      w_run_nxt    = r_run;
      w_pulse_nxt  = 1'b0;
      w_sep_id_nxt = r_sep_id;
      w_isp_nxt    = r_isp;
      w_iw_nxt     = r_iw;
      w_wp_nxt     = r_wp;
      w_bt_nxt     = r_bt;
      w_done_nxt   = r_done;
      w_fault_nxt  = r_fault;

      if (w_abort) begin
         w_state_nxt = ST_FAULT;
         w_run_nxt   = 1'b0;
         w_fault_nxt = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (START) begin
                  w_stage_nxt = 4'd1;
                  w_mass_nxt  = C_LIFTOFF_MASS;
                  w_state_nxt = ST_LOAD;
               end
            end
            ST_LOAD: begin
               w_isp_nxt   = w_rom_isp;
               w_wp_nxt    = w_rom_prop;
               w_bt_nxt    = w_rom_burn;
               w_iw_nxt    = r_mass;
               w_cnt_nxt   = '0;
               w_run_nxt   = 1'b1;
               w_state_nxt = ST_BURN;
            end
            ST_BURN: begin
               // r_cnt is 0 during the first BURN cycle, so a level left
               // over from the previous phase cannot end this burn at once.
               if (IGNITION_END && (r_cnt != '0)) begin
                  w_run_nxt    = 1'b0;
                  w_pulse_nxt  = 1'b1;
                  w_sep_id_nxt = r_stage;
                  w_cnt_nxt    = '0;
                  if (w_underflow) begin
                     w_mass_nxt  = '0;
                     w_fault_nxt = 1'b1;
                     w_state_nxt = ST_FAULT;
                  end else begin
                     w_mass_nxt  = r_mass - w_jettison;
                     w_state_nxt = ST_SEP;
                  end
               end else if (r_cnt == C_BURN_LAST) begin
                  w_run_nxt   = 1'b0;
                  w_fault_nxt = 1'b1;
                  w_state_nxt = ST_FAULT;
               end else begin
                  w_cnt_nxt = r_cnt + 32'd1;
               end
            end
            ST_SEP: begin
               if (r_cnt == C_SEP_LAST) begin
                  w_cnt_nxt = '0;
                  if (r_stage == 4'(NUM_STAGES)) begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_stage_nxt = r_stage + 4'd1;
                     w_state_nxt = ST_LOAD;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 32'd1;
               end
            end
            ST_DONE: begin
               w_run_nxt = 1'b0;
            end
            ST_FAULT: begin
               w_run_nxt   = 1'b0;
               w_fault_nxt = 1'b1;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         r_state  <= ST_IDLE;
         r_stage  <= '0;
         r_mass   <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b0;
         r_pulse  <= 1'b0;
         r_sep_id <= '0;
         r_isp    <= '0;
         r_iw     <= '0;
         r_wp     <= '0;
         r_bt     <= N'(1);
         r_done   <= 1'b0;
         r_fault  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_stage  <= w_stage_nxt;
         r_mass   <= w_mass_nxt;
         r_cnt    <= w_cnt_nxt;
         r_run    <= w_run_nxt;
         r_pulse  <= w_pulse_nxt;
         r_sep_id <= w_sep_id_nxt;
         r_isp    <= w_isp_nxt;
         r_iw     <= w_iw_nxt;
         r_wp     <= w_wp_nxt;
         r_bt     <= w_bt_nxt;
         r_done   <= w_done_nxt;
         r_fault  <= w_fault_nxt;
      end
   end

   assign ENGINE_RUN        = r_run;
   assign SPECIFICIMPULSE   = r_isp;
   assign INITIALWEIGHT     = r_iw;
   assign WEIGHT_PROPELLANT = r_wp;
   assign BURNTIME          = r_bt;
   assign STAGESTATE        = r_stage;
   assign SEP_PULSE         = r_pulse;
   assign SEP_ID            = r_sep_id;
   assign DONE              = r_done;
   assign FAULT             = r_fault;

endmodule : stage_sequencer
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_stage_sequencer
//  Description : Self-checking bench for stage_sequencer. Randomised burn
//                lengths; expected parameters and masses come from the
//                phase tables and plain mass arithmetic.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_sequencer;

   localparam int unsigned N  = 64;
   localparam int unsigned TO = 100;

   logic         CLK = 1'b0;
   logic         RESETB = 1'b0;
   logic         START = 1'b0;
   logic         ABORT = 1'b0;
   logic         IGNITION_END = 1'b0;
   logic         ENGINE_RUN;
   logic [N-1:0] SPECIFICIMPULSE, INITIALWEIGHT, WEIGHT_PROPELLANT, BURNTIME;
   logic [3:0]   STAGESTATE, SEP_ID;
   logic         SEP_PULSE, DONE, FAULT;

   int errors = 0;
   int checks = 0;

   logic [3:0]  sep_q[$];
   logic [63:0] m_mass;
   logic [63:0] m_last_iw;

   logic [63:0] M_ISP  [4] = '{64'd263, 64'd421, 64'd421, 64'd421};
   logic [63:0] M_PROP [4] = '{64'd2077000, 64'd456100, 64'd39136, 64'd83864};
   logic [63:0] M_BURN [4] = '{64'd168, 64'd360, 64'd165, 64'd335};
   logic [63:0] M_DROP [4] = '{64'd137000, 64'd40100, 64'd0, 64'd15200};
   logic [63:0] M_PAYLOAD  = 64'd27003;

   stage_sequencer #(.TIMEOUT(TO)) dut (
      .CLK               (CLK),
      .RESETB            (RESETB),
      .START             (START),
      .ABORT             (ABORT),
      .IGNITION_END      (IGNITION_END),
      .ENGINE_RUN        (ENGINE_RUN),
      .SPECIFICIMPULSE   (SPECIFICIMPULSE),
      .INITIALWEIGHT     (INITIALWEIGHT),
      .WEIGHT_PROPELLANT (WEIGHT_PROPELLANT),
      .BURNTIME          (BURNTIME),
      .STAGESTATE        (STAGESTATE),
      .SEP_PULSE         (SEP_PULSE),
      .SEP_ID            (SEP_ID),
      .DONE              (DONE),
      .FAULT             (FAULT)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (RESETB && SEP_PULSE) sep_q.push_back(SEP_ID);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      RESETB = 1'b0;
      START = 1'b0;
      ABORT = 1'b0;
      IGNITION_END = 1'b0;
      repeat (2) tick();
      RESETB = 1'b1;
      sep_q.delete();
   endtask

   task automatic start_flight();
      START = 1'b1;
      tick();
      START = 1'b0;
      m_mass = M_PAYLOAD;
      for (int i = 0; i < 4; i++) m_mass = m_mass + M_PROP[i] + M_DROP[i];
   endtask

   task automatic wait_run(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ENGINE_RUN === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (DONE === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // One burn: parameters on entry, stability for d cycles, end of burn.
   task automatic fly_phase(input int k, input int d, input bit hold_ign,
                            input bit start_mid);
      bit ok;
      wait_run(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL run_rise phase %0d: ENGINE_RUN=%0b required 1", k, ENGINE_RUN);
         return;
      end
      checks++;
      if (STAGESTATE !== 4'(k)) begin
         errors++;
         $display("FAIL stagestate phase %0d: got %0d required %0d", k, STAGESTATE, k);
      end
      checks++;
      if (INITIALWEIGHT !== m_mass) begin
         errors++;
         $display("FAIL initialweight phase %0d: got %0d required %0d", k, INITIALWEIGHT, m_mass);
      end
      checks++;
      if ({SPECIFICIMPULSE, WEIGHT_PROPELLANT, BURNTIME} !== {M_ISP[k-1], M_PROP[k-1], M_BURN[k-1]}) begin
         errors++;
         $display("FAIL params phase %0d: got isp=%0d prop=%0d burn=%0d required isp=%0d prop=%0d burn=%0d",
                  k, SPECIFICIMPULSE, WEIGHT_PROPELLANT, BURNTIME, M_ISP[k-1], M_PROP[k-1], M_BURN[k-1]);
      end
      for (int i = 0; i < d; i++) begin
         START = start_mid && (i == 0);
         tick();
      end
      START = 1'b0;
      checks++;
      if ({ENGINE_RUN, SEP_PULSE, STAGESTATE, INITIALWEIGHT, SPECIFICIMPULSE} !==
          {1'b1, 1'b0, 4'(k), m_mass, M_ISP[k-1]}) begin
         errors++;
         $display("FAIL burn_stable phase %0d: run=%0b pulse=%0b stage=%0d iw=%0d required run=1 pulse=0 stage=%0d iw=%0d",
                  k, ENGINE_RUN, SEP_PULSE, STAGESTATE, INITIALWEIGHT, k, m_mass);
      end
      IGNITION_END = 1'b1;
      tick();
      if (!hold_ign) IGNITION_END = 1'b0;
      checks++;
      if ({ENGINE_RUN, SEP_PULSE, SEP_ID} !== {1'b0, 1'b1, 4'(k)}) begin
         errors++;
         $display("FAIL sep_entry phase %0d: run=%0b pulse=%0b id=%0d required run=0 pulse=1 id=%0d",
                  k, ENGINE_RUN, SEP_PULSE, SEP_ID, k);
      end
      m_last_iw = m_mass;
      m_mass = m_mass - M_PROP[k-1] - M_DROP[k-1];
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({ENGINE_RUN, SEP_PULSE, DONE, FAULT, STAGESTATE, SEP_ID} !== 12'd0) begin
         errors++;
         $display("FAIL reset_flags: got %b required 0", {ENGINE_RUN, SEP_PULSE, DONE, FAULT, STAGESTATE, SEP_ID});
      end
      checks++;
      if ({SPECIFICIMPULSE, INITIALWEIGHT, WEIGHT_PROPELLANT, BURNTIME} !== {64'd0, 64'd0, 64'd0, 64'd1}) begin
         errors++;
         $display("FAIL reset_params: got isp=%0d iw=%0d wp=%0d bt=%0d required 0 0 0 1",
                  SPECIFICIMPULSE, INITIALWEIGHT, WEIGHT_PROPELLANT, BURNTIME);
      end
      ABORT = 1'b1;
      IGNITION_END = 1'b1;
      repeat (4) tick();
      ABORT = 1'b0;
      IGNITION_END = 1'b0;
      checks++;
      if ({ENGINE_RUN, FAULT, DONE, STAGESTATE} !== 7'd0) begin
         errors++;
         $display("FAIL idle_ignores: run=%0b fault=%0b done=%0b stage=%0d required all 0",
                  ENGINE_RUN, FAULT, DONE, STAGESTATE);
      end
   endtask

   task automatic test_full_flight();
      bit ok;
      for (int f = 0; f < 3; f++) begin
         apply_reset();
         start_flight();
         for (int k = 1; k <= 4; k++) fly_phase(k, int'($urandom_range(1, 40)), 1'b0, 1'b0);
         wait_done(ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL done_wait: DONE=%0b required 1", DONE);
         end
         repeat (3) tick();
         checks++;
         if ({DONE, FAULT, ENGINE_RUN, STAGESTATE} !== {1'b1, 1'b0, 1'b0, 4'd4}) begin
            errors++;
            $display("FAIL done_state: done=%0b fault=%0b run=%0b stage=%0d required 1 0 0 4",
                     DONE, FAULT, ENGINE_RUN, STAGESTATE);
         end
         checks++;
         if ({INITIALWEIGHT, SPECIFICIMPULSE, WEIGHT_PROPELLANT} !== {m_last_iw, M_ISP[3], M_PROP[3]}) begin
            errors++;
            $display("FAIL done_retain: iw=%0d isp=%0d wp=%0d required %0d %0d %0d",
                     INITIALWEIGHT, SPECIFICIMPULSE, WEIGHT_PROPELLANT, m_last_iw, M_ISP[3], M_PROP[3]);
         end
         checks++;
         if (sep_q.size() != 4 || sep_q[0] !== 4'd1 || sep_q[1] !== 4'd2 ||
             sep_q[2] !== 4'd3 || sep_q[3] !== 4'd4) begin
            errors++;
            $display("FAIL sep_sequence: got %0d pulses %p required 4 pulses ids 1..4", sep_q.size(), sep_q);
         end
      end
      checks++;
      if (m_last_iw !== 64'd126067) begin
         errors++;
         $display("FAIL model_phase4_mass: got %0d required 126067", m_last_iw);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int run_n;
      apply_reset();
      start_flight();
      wait_run(ok);
      run_n = 1;
      for (int i = 0; i < 2 * TO; i++) begin
         tick();
         if (FAULT === 1'b1) break;
         run_n++;
      end
      checks++;
      if (!ok || run_n != TO) begin
         errors++;
         $display("FAIL timeout_cycle: fault after %0d burn cycles required %0d", run_n, TO);
      end
      checks++;
      if ({FAULT, ENGINE_RUN, SEP_PULSE, STAGESTATE} !== {1'b1, 1'b0, 1'b0, 4'd1} || sep_q.size() != 0) begin
         errors++;
         $display("FAIL timeout_state: fault=%0b run=%0b stage=%0d pulses=%0d required 1 0 1 0",
                  FAULT, ENGINE_RUN, STAGESTATE, sep_q.size());
      end
   endtask

   task automatic test_abort_priority();
      bit ok;
      apply_reset();
      start_flight();
      fly_phase(1, int'($urandom_range(1, 40)), 1'b0, 1'b0);
      wait_run(ok);
      repeat ($urandom_range(1, 30)) tick();
      ABORT = 1'b1;
      IGNITION_END = 1'b1;
      tick();
      ABORT = 1'b0;
      IGNITION_END = 1'b0;
      checks++;
      if (!ok || {FAULT, ENGINE_RUN, SEP_PULSE, STAGESTATE} !== {1'b1, 1'b0, 1'b0, 4'd2}) begin
         errors++;
         $display("FAIL abort_priority: fault=%0b run=%0b pulse=%0b stage=%0d required 1 0 0 2",
                  FAULT, ENGINE_RUN, SEP_PULSE, STAGESTATE);
      end
      repeat (4) tick();
      checks++;
      if ({FAULT, DONE, STAGESTATE} !== {1'b1, 1'b0, 4'd2} || sep_q.size() != 1) begin
         errors++;
         $display("FAIL abort_hold: fault=%0b done=%0b stage=%0d pulses=%0d required 1 0 2 1",
                  FAULT, DONE, STAGESTATE, sep_q.size());
      end
   endtask

   task automatic test_reset_mid_burn();
      bit ok;
      apply_reset();
      start_flight();
      fly_phase(1, int'($urandom_range(1, 40)), 1'b0, 1'b0);
      fly_phase(2, int'($urandom_range(1, 40)), 1'b0, 1'b0);
      wait_run(ok);
      repeat ($urandom_range(1, 30)) tick();
      #2 RESETB = 1'b0;
      #1;
      checks++;
      if (!ok || {ENGINE_RUN, SEP_PULSE, DONE, FAULT, STAGESTATE, SEP_ID} !== 12'd0) begin
         errors++;
         $display("FAIL midburn_reset_flags: got %b required 0",
                  {ENGINE_RUN, SEP_PULSE, DONE, FAULT, STAGESTATE, SEP_ID});
      end
      checks++;
      if ({SPECIFICIMPULSE, INITIALWEIGHT, WEIGHT_PROPELLANT, BURNTIME} !== {64'd0, 64'd0, 64'd0, 64'd1}) begin
         errors++;
         $display("FAIL midburn_reset_params: isp=%0d iw=%0d wp=%0d bt=%0d required 0 0 0 1",
                  SPECIFICIMPULSE, INITIALWEIGHT, WEIGHT_PROPELLANT, BURNTIME);
      end
      repeat (2) tick();
      checks++;
      if (sep_q.size() != 2) begin
         errors++;
         $display("FAIL midburn_no_pulse: got %0d pulses required 2", sep_q.size());
      end
      RESETB = 1'b1;
      start_flight();
      wait_run(ok);
      checks++;
      if (!ok || STAGESTATE !== 4'd1 || INITIALWEIGHT !== 64'd2875403) begin
         errors++;
         $display("FAIL restart: stage=%0d iw=%0d required 1 2875403", STAGESTATE, INITIALWEIGHT);
      end
   endtask

   task automatic test_stale_level();
      bit ok;
      int run_n;
      apply_reset();
      start_flight();
      fly_phase(1, int'($urandom_range(1, 40)), 1'b1, 1'b0);
      wait_run(ok);
      checks++;
      if (!ok || STAGESTATE !== 4'd2 || INITIALWEIGHT !== m_mass) begin
         errors++;
         $display("FAIL stale_entry: stage=%0d iw=%0d required 2 %0d", STAGESTATE, INITIALWEIGHT, m_mass);
      end
      run_n = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ENGINE_RUN !== 1'b1) break;
         run_n++;
      end
      IGNITION_END = 1'b0;
      checks++;
      if (run_n != 2 || SEP_PULSE !== 1'b1 || SEP_ID !== 4'd2) begin
         errors++;
         $display("FAIL stale_ignored: burn lasted %0d cycles pulse=%0b id=%0d required 2 1 2",
                  run_n, SEP_PULSE, SEP_ID);
      end
      m_mass = m_mass - M_PROP[1] - M_DROP[1];
      fly_phase(3, int'($urandom_range(1, 40)), 1'b0, 1'b0);
      fly_phase(4, int'($urandom_range(1, 40)), 1'b0, 1'b0);
      wait_done(ok);
      checks++;
      if (!ok || sep_q.size() != 4 || sep_q[0] !== 4'd1 || sep_q[1] !== 4'd2) begin
         errors++;
         $display("FAIL stale_pulses: done=%0b pulses=%0d %p required done with 4 pulses ids 1..4",
                  DONE, sep_q.size(), sep_q);
      end
   endtask

   task automatic test_ignored_start();
      bit ok;
      apply_reset();
      start_flight();
      fly_phase(1, int'($urandom_range(2, 40)), 1'b0, 1'b1);
      fly_phase(2, int'($urandom_range(2, 40)), 1'b0, 1'b1);
      fly_phase(3, int'($urandom_range(2, 40)), 1'b0, 1'b0);
      fly_phase(4, int'($urandom_range(2, 40)), 1'b0, 1'b1);
      wait_done(ok);
      checks++;
      if (!ok || FAULT !== 1'b0 || STAGESTATE !== 4'd4 || sep_q.size() != 4) begin
         errors++;
         $display("FAIL start_ignored: done=%0b fault=%0b stage=%0d pulses=%0d required 1 0 4 4",
                  DONE, FAULT, STAGESTATE, sep_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_full_flight();
      test_timeout();
      test_abort_priority();
      test_reset_mid_burn();
      test_stale_level();
      test_ignored_start();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_stage_sequencer
`default_nettype wire

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The module SHALL have parameter N, default 64, the width of every mass, impulse and time datapath word.
REQ-002 The module SHALL have parameter NUM_STAGES, default 4, the number of burn phases (3rd-stage split burn counts as phases 3 and 4).
REQ-003 The module SHALL have parameter SEP_CYCLES, default 2, the number of cycles the engine is held off between burns.
REQ-004 The module SHALL have parameter TIMEOUT, default 2_000_000, the maximum cycles per burn before fault.
REQ-005 The module SHALL have per-phase parameters ISP_k (263,421,421,421), PROP_k (2077000,456100,39136,83864), BURN_k (168,360,165,335) and DROP_k (137000,40100,0,15200), plus PAYLOAD (27003 = LM+CMSM).
REQ-006 The module SHALL have port CLK, input, 1 bit: clock.
REQ-007 The module SHALL have port RESETB, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The module SHALL have port START, input, 1 bit: one-cycle liftoff request.
REQ-009 The module SHALL have port ABORT, input, 1 bit: level; forces FAULT.
REQ-010 The module SHALL have port IGNITION_END, input, 1 bit: burn-complete from velocity engine.
REQ-011 The module SHALL have port ENGINE_RUN, output, 1 bit: active-high enable; the engine's resetb connects to this signal.
REQ-012 The module SHALL have ports SPECIFICIMPULSE, INITIALWEIGHT, WEIGHT_PROPELLANT and BURNTIME, outputs, N bits each: current-phase engine parameters.
REQ-013 The module SHALL have port STAGESTATE, output, 4 bits: active phase (0 = none, 1..NUM_STAGES).
REQ-014 The module SHALL have ports SEP_PULSE, output, 1 bit, and SEP_ID, output, 4 bits: one-cycle end-of-phase event and its phase number.
REQ-015 The module SHALL have ports DONE and FAULT, outputs, 1 bit each: sticky status flags.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, BURN, SEP, DONE and FAULT.
REQ-017 In IDLE, START SHALL set STAGESTATE=1 and the mass register to the sum of all PROP_k, all DROP_k and PAYLOAD (2875403), then go to LOAD; all other inputs are ignored in IDLE.
REQ-018 LOAD SHALL last exactly 1 cycle and register ISP/PROP/BURN of the current STAGESTATE, with INITIALWEIGHT taken from the mass register.
REQ-019 ENGINE_RUN SHALL be 0 in LOAD and SHALL rise on the cycle BURN is entered.
REQ-020 Parameter outputs SHALL be stable for the whole of BURN.
REQ-021 BURN SHALL count cycles from 0; IGNITION_END=1 SHALL go to SEP, and reaching count TIMEOUT first SHALL go to FAULT.
REQ-022 IGNITION_END SHALL be honoured only in BURN, and only from the second BURN cycle onward; a stale level from the previous phase is ignored.
REQ-023 On SEP entry: ENGINE_RUN=0; SEP_PULSE=1 for exactly one cycle with SEP_ID=STAGESTATE; mass becomes mass - PROP_k - DROP_k.
REQ-024 If that subtraction would go below zero, the mass register SHALL saturate to 0 and the FSM SHALL go to FAULT.
REQ-025 SEP SHALL last SEP_CYCLES cycles, then go to DONE if STAGESTATE==NUM_STAGES, else increment STAGESTATE and go to LOAD.
REQ-026 DONE SHALL set DONE=1, keep ENGINE_RUN=0, retain STAGESTATE and all parameter outputs, and hold until reset.
REQ-027 ABORT=1 in any state other than IDLE SHALL enter FAULT on the next edge, with priority over IGNITION_END and the timeout.
REQ-028 FAULT SHALL set FAULT=1 and ENGINE_RUN=0 and hold until reset.
REQ-029 START SHALL be ignored outside IDLE.
REQ-030 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Reset
REQ-031 RESETB low SHALL asynchronously force IDLE.
REQ-032 RESETB low SHALL drive ENGINE_RUN=0, SEP_PULSE=0, DONE=0, FAULT=0, STAGESTATE=0, SEP_ID=0, SPECIFICIMPULSE=0, INITIALWEIGHT=0, WEIGHT_PROPELLANT=0, BURNTIME=1 and the mass register to 0, and SHALL clear the burn counter.
REQ-033 A reset asserted mid-BURN SHALL drop ENGINE_RUN within the same reset assertion, with no SEP_PULSE emitted.

Structure
REQ-034 Shared package stage_pkg SHALL hold the FSM state encoding, the default per-phase constant tables and the PAYLOAD constant.
REQ-035 The per-phase parameter lookup (STAGESTATE to ISP/PROP/BURN/DROP) SHALL be one combinational sub-module, stage_rom.
REQ-036 The FSM, counters and mass accumulator SHALL stay in the top-level module.

Verification
REQ-037 Full-flight scenario: START, then IGNITION_END after each of the 4 burns -> INITIALWEIGHT = 2875403, 661403, 165203, 126067 in turn; 4 SEP_PULSEs with SEP_ID 1..4; then DONE=1.
REQ-038 Timeout scenario: TIMEOUT=100, IGNITION_END never asserted -> FAULT=1 at BURN cycle 100 with ENGINE_RUN=0 and no SEP_PULSE.
REQ-039 ABORT-priority scenario: ABORT and IGNITION_END asserted together in phase 2 -> FAULT=1, no SEP_PULSE, STAGESTATE held at 2.
REQ-040 Reset-mid-burn scenario: RESETB low in phase 3 -> all outputs at reset values; a following START restarts at phase 1 with INITIALWEIGHT 2875403.
REQ-041 Stale-level scenario: IGNITION_END held high across SEP into the next BURN -> not honoured in the first BURN cycle; SEP_PULSE occurs once per phase.
REQ-042 Ignored-START scenario: START pulsed during BURN -> no state change and no effect on STAGESTATE.
